// File: rtl/axis_mac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axis_mac_pkg
// Brief    : Register map, FSM encoding and slice helpers for the MAC downsizer.
// Revision : 1.0
// ============================================================================
package axis_mac_pkg;

  localparam logic [15:0] c_reg_frames = 16'h0000;
  localparam logic [15:0] c_reg_errors = 16'h0004;
  localparam logic [15:0] c_reg_beats  = 16'h0008;
  localparam logic [15:0] c_reg_stalls = 16'h000C;
  localparam logic [15:0] c_reg_widths = 16'h0010;

  // Widest strobe vector the final-slice search handles (IN_W up to 1024).
  localparam int c_max_strb_w = 128;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Highest slice holding any valid byte; slice 0 when the strobe is all zero.
  function automatic int final_slice(input logic [c_max_strb_w-1:0] strb,
                                     input int ratio, input int slice_b);
    int r;
    r = 0;
    for (int i = 0; i < c_max_strb_w; i++) begin
      if ((i < ratio * slice_b) && strb[i]) r = i / slice_b;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_stat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mac_stat_cnt
// Brief    : Saturating statistics counter with increment enable.
// Revision : 1.0
// ============================================================================
module mac_stat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/axis_mac_downsizer.sv
`default_nettype none
// ============================================================================
// Module   : axis_mac_downsizer
// Brief    : AXI-Stream wide-to-narrow converter with end-of-frame trimming
//            and saturating statistics readable over the host read handshake.
// Revision : 1.0
// ============================================================================
module axis_mac_downsizer
  import axis_mac_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 64,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      s_axis_tdata,
  input  logic [IN_W/8-1:0]    s_axis_tstrb,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_tready,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic [OUT_W/8-1:0]   m_axis_tstrb,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  input  logic [15:0]          host_addr_reg,
  input  logic                 reg_rd_start,
  output logic                 reg_rd_done_out,
  output logic [31:0]          reg_rdout
);

  localparam int RATIO   = IN_W / OUT_W;
  localparam int c_in_b  = IN_W / 8;
  localparam int c_out_b = OUT_W / 8;
  localparam int c_idx_w = idx_width(RATIO);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(RATIO - 1);

  state_e               state_q, state_d;
  logic [c_idx_w-1:0]   idx_q, idx_d;
  logic                 rdy_en_q;
  logic [IN_W-1:0]      hold_data_q;
  logic [c_in_b-1:0]    hold_strb_q;
  logic                 hold_last_q;
  logic                 hold_user_q;
  logic                 rd_done_q;
  logic [31:0]          rdout_q;

  logic [c_idx_w-1:0]   w_final_idx;
  logic                 w_is_final;
  logic                 w_fin_hs;
  logic                 w_m_hs;
  logic                 w_s_acc;
  logic [31:0]          w_rd_data;
  logic [3:0]           w_cnt_inc;
  logic [CNT_W-1:0]     w_cnt [4];

  assign w_final_idx = hold_last_q
                     ? c_idx_w'(final_slice(c_max_strb_w'(hold_strb_q), RATIO, c_out_b))
                     : c_last_idx;
  assign w_is_final  = (idx_q == w_final_idx);
  assign w_fin_hs    = (state_q == ST_DRAIN) && m_axis_tready && w_is_final;
  assign w_m_hs      = m_axis_tvalid && m_axis_tready;
  assign w_s_acc     = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_EMPTY: if (w_s_acc) state_d = ST_DRAIN;
      ST_DRAIN: if (w_fin_hs && !w_s_acc) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (w_s_acc) begin
      idx_d = '0;
    end else if (w_m_hs && !w_is_final) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Refilling on the final-slice handshake keeps full-rate streams bubble-free.
  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_q)
      ST_EMPTY: s_axis_tready = rdy_en_q;
      ST_DRAIN: begin
        m_axis_tvalid = 1'b1;
        s_axis_tready = rdy_en_q && w_fin_hs;
        m_axis_tlast  = hold_last_q && w_is_final;
        m_axis_tuser  = hold_user_q && hold_last_q && w_is_final;
      end
      default: ;
    endcase
  end

  assign m_axis_tdata = hold_data_q[idx_q*OUT_W +: OUT_W];
  assign m_axis_tstrb = hold_strb_q[idx_q*c_out_b +: c_out_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q    <= 1'b0;
      idx_q       <= '0;
      hold_data_q <= '0;
      hold_strb_q <= '0;
      hold_last_q <= 1'b0;
      hold_user_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      idx_q    <= idx_d;
      if (w_s_acc) begin
        hold_data_q <= s_axis_tdata;
        hold_strb_q <= s_axis_tstrb;
        hold_last_q <= s_axis_tlast;
        hold_user_q <= s_axis_tuser && s_axis_tlast;
      end
    end
  end

  assign w_cnt_inc[0] = w_m_hs && m_axis_tlast;
  assign w_cnt_inc[1] = w_m_hs && m_axis_tlast && m_axis_tuser;
  assign w_cnt_inc[2] = w_m_hs;
  assign w_cnt_inc[3] = m_axis_tvalid && !m_axis_tready;

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    mac_stat_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (w_cnt_inc[g]),
      .cnt_o (w_cnt[g])
    );
  end

  always_comb begin
    w_rd_data = '0;
    case (host_addr_reg)
      c_reg_frames: w_rd_data = 32'(w_cnt[0]);
      c_reg_errors: w_rd_data = 32'(w_cnt[1]);
      c_reg_beats:  w_rd_data = 32'(w_cnt[2]);
      c_reg_stalls: w_rd_data = 32'(w_cnt[3]);
      c_reg_widths: w_rd_data = {16'(IN_W), 16'(OUT_W)};
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done_q <= 1'b0;
      rdout_q   <= '0;
    end else begin
      rd_done_q <= reg_rd_start;
      if (reg_rd_start) rdout_q <= w_rd_data;
    end
  end

  assign reg_rd_done_out = rd_done_q;
  assign reg_rdout       = rdout_q;

endmodule
`default_nettype wire
